// File: rtl/rv32i_mem_arbiter_if.sv
// rv32i_mem_arbiter_if: requester and memory-port signals of the fetch/data
// memory arbiter. The arbiter connects through the slave modport; the
// requesters/memory side (the bench) uses the master modport.
interface rv32i_mem_arbiter_if #(
    parameter int XLEN     = 32,
    parameter int PORT_LEN = 16
);
    // fetch requester
    logic                if_req_i;
    logic [XLEN-1:0]     if_addr_i;
    logic                if_ack_o;
    logic                if_err_o;
    logic [XLEN-1:0]     if_rdata_o;
    // load/store requester
    logic                d_req_i;
    logic                d_we_i;
    logic [1:0]          d_size_i;
    logic [XLEN-1:0]     d_addr_i;
    logic [XLEN-1:0]     d_wdata_i;
    logic                d_ack_o;
    logic                d_err_o;
    logic [XLEN-1:0]     d_rdata_o;
    // shared 16-bit memory port
    logic                mem_read_o;
    logic                mem_write_o;
    logic [XLEN-1:0]     mem_addr_o;
    logic [1:0]          mem_be_o;
    logic [PORT_LEN-1:0] mem_data_o;
    logic [PORT_LEN-1:0] mem_data_i;

    modport slave (
        input  if_req_i, if_addr_i,
        input  d_req_i, d_we_i, d_size_i, d_addr_i, d_wdata_i,
        input  mem_data_i,
        output if_ack_o, if_err_o, if_rdata_o,
        output d_ack_o, d_err_o, d_rdata_o,
        output mem_read_o, mem_write_o, mem_addr_o, mem_be_o, mem_data_o
    );

    modport master (
        output if_req_i, if_addr_i,
        output d_req_i, d_we_i, d_size_i, d_addr_i, d_wdata_i,
        output mem_data_i,
        input  if_ack_o, if_err_o, if_rdata_o,
        input  d_ack_o, d_err_o, d_rdata_o,
        input  mem_read_o, mem_write_o, mem_addr_o, mem_be_o, mem_data_o
    );
endinterface

// File: rtl/rv32i_mem_arbiter.sv
// rv32i_mem_arbiter: shares one 16-bit memory port between the instruction
// fetch and load/store requesters. Word accesses become two halfword beats,
// byte/half accesses one beat; misaligned requests are answered with an
// error ack and never reach memory.
// Optional feature macro: RV32I_ARB_RR_EN -- round-robin grant on contention.
// Without it the data requester always wins over fetch.
module rv32i_mem_arbiter #(
    parameter int XLEN     = 32,
    parameter int PORT_LEN = 16
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    rv32i_mem_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BEAT0 = 3'd1,
        S_BEAT1 = 3'd2,
        S_CAPT  = 3'd3,
        S_RESP  = 3'd4,
        S_ERR   = 3'd5
    } state_e;

    // Normalised access sizes held in size_q (encoding 3 folds into word).
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    state_e          state_q, state_d;
    logic            owner_q, owner_d;     // 1 = data requester, 0 = fetch
    logic            we_q, we_d;
    logic [1:0]      size_q, size_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
`ifdef RV32I_ARB_RR_EN
    logic            last_grant_q, last_grant_d;  // 1 = data got the last grant
`endif

    logic            pick_data;
    logic [1:0]      req_size;
    logic [XLEN-1:0] req_addr;
    logic            misaligned;
    logic [XLEN-1:0] base_addr;
    logic [7:0]      byte_lane;

    assign base_addr = {addr_q[XLEN-1:1], 1'b0};
    assign byte_lane = addr_q[0] ? bus.mem_data_i[15:8] : bus.mem_data_i[7:0];

    // Grant selection and access-shape decode of the requester seen in IDLE.
    always_comb begin
`ifdef RV32I_ARB_RR_EN
        pick_data = bus.d_req_i && (!bus.if_req_i || !last_grant_q);
`else
        pick_data = bus.d_req_i;
`endif
        req_addr = pick_data ? bus.d_addr_i : bus.if_addr_i;
        req_size = SZ_WORD;
        if (pick_data && (bus.d_size_i != 2'd3)) req_size = bus.d_size_i;
        misaligned = ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00)) ||
                     ((req_size == SZ_HALF) && req_addr[0]);
    end

    // Next-state: grant in IDLE, walk the beats, assemble read data.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef RV32I_ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.if_req_i || bus.d_req_i) begin
                    owner_d = pick_data;
                    we_d    = pick_data && bus.d_we_i;
                    size_d  = req_size;
                    addr_d  = req_addr;
                    wdata_d = pick_data ? bus.d_wdata_i : '0;
                    rdata_d = '0;
                    state_d = misaligned ? S_ERR : S_BEAT0;
`ifdef RV32I_ARB_RR_EN
                    last_grant_d = pick_data;
`endif
                end
            end
            S_BEAT0: state_d = (size_q == SZ_WORD) ? S_BEAT1 : S_CAPT;
            S_BEAT1: begin
                // data for the beat-0 read arrives now: low halfword
                if (!we_q) rdata_d[PORT_LEN-1:0] = bus.mem_data_i;
                state_d = S_CAPT;
            end
            S_CAPT: begin
                if (!we_q) begin
                    case (size_q)
                        SZ_BYTE: rdata_d = {{(XLEN-8){1'b0}}, byte_lane};
                        SZ_HALF: rdata_d = {{(XLEN-PORT_LEN){1'b0}}, bus.mem_data_i};
                        default: rdata_d = {bus.mem_data_i, rdata_q[PORT_LEN-1:0]};
                    endcase
                end
                state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef RV32I_ARB_RR_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef RV32I_ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // Memory port: strobes, address, lanes and data only during the beats.
    always_comb begin
        bus.mem_read_o  = 1'b0;
        bus.mem_write_o = 1'b0;
        bus.mem_addr_o  = '0;
        bus.mem_be_o    = 2'b00;
        bus.mem_data_o  = '0;
        if ((state_q == S_BEAT0) || (state_q == S_BEAT1)) begin
            bus.mem_read_o  = !we_q;
            bus.mem_write_o = we_q;
            // base+2 wraps naturally in XLEN bits
            bus.mem_addr_o  = (state_q == S_BEAT1) ? base_addr + XLEN'(2) : base_addr;
            if (size_q == SZ_BYTE) begin
                bus.mem_be_o   = addr_q[0] ? 2'b10 : 2'b01;
                bus.mem_data_o = {2{wdata_q[7:0]}};
            end else begin
                bus.mem_be_o   = 2'b11;
                bus.mem_data_o = (state_q == S_BEAT1) ? wdata_q[XLEN-1:PORT_LEN]
                                                      : wdata_q[PORT_LEN-1:0];
            end
        end
    end

    // Requester responses: one-cycle ack to the owner; rdata only with a read ack.
    always_comb begin
        bus.if_ack_o   = ((state_q == S_RESP) || (state_q == S_ERR)) && !owner_q;
        bus.if_err_o   = (state_q == S_ERR) && !owner_q;
        bus.if_rdata_o = ((state_q == S_RESP) && !owner_q) ? rdata_q : '0;
        bus.d_ack_o    = ((state_q == S_RESP) || (state_q == S_ERR)) && owner_q;
        bus.d_err_o    = (state_q == S_ERR) && owner_q;
        bus.d_rdata_o  = ((state_q == S_RESP) && owner_q) ? rdata_q : '0;
    end

endmodule
